uart_hex_tx: RTL and testbench
==============================

Name: uart_hex_tx

Overview:
- Downstream formatter that prints fixed-width words as lowercase ASCII hex on the UART transmit byte stream. Sits directly upstream of the JTAG UART transmit port and drives its tx_valid/tx_data.
- Accepts one word per valid/ready handshake and emits DIGITS hex characters, MSB nibble first. Each word is optionally followed by CR LF.
- Used for debug tracing (PC, register dumps) from the core.

Parameters:
- DIGITS, 8, hex digits per word; in_data width is 4*DIGITS; legal range 1..16.
- NEWLINE, 1, when 1 append 0x0D then 0x0A after each word; when 0 emit digits only.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_ready  output  1  high when a new word can be accepted.
- in_valid  input  1  word request.
- in_data  input  4*DIGITS  word to print.
- tx_ready  input  1  UART transmitter can take a byte.
- tx_valid  output  1  byte on tx_data is valid.
- tx_data  output  8  ASCII byte.

Behaviour:
- Reset values (asynchronous, immediate on reset assertion):
  - state=IDLE, tx_valid=0, tx_data=0x00, in_ready=1 after reset deasserts, word register=0, digit count=0.
- States: IDLE, DIGIT, CR, LF.
  - in_ready = (state==IDLE), decoded directly from the state register.
  - tx_valid is a register and is 1 exactly when state is DIGIT, CR or LF.
- IDLE:
  - On in_valid&in_ready at edge N: latch in_data, set count=DIGITS-1, enter DIGIT.
  - Load tx_data with the hex char of nibble [4*DIGITS-1 -: 4].
  - tx_valid is high from cycle N+1, i.e. one cycle of latency.
- Hex encoding: nibble 0..9 -> 0x30..0x39; nibble 10..15 -> 0x61..0x66 ('a'..'f').
- DIGIT:
  - On tx_valid&tx_ready with count!=0: decrement count and load tx_data with the next lower nibble.
  - On the handshake with count==0: if NEWLINE, enter CR with tx_data=0x0D; otherwise enter IDLE with tx_valid=0.
- CR: on the handshake, enter LF with tx_data=0x0A.
- LF: on the handshake, enter IDLE with tx_valid=0.
- Output hold: while tx_valid=1 and tx_ready=0, tx_data and state hold unchanged for any number of cycles. The output never retracts tx_valid without a handshake (reset excepted).
- Throughput:
  - One byte per cycle while tx_ready stays high.
  - After the last byte of a word is taken, in_ready rises on the next cycle, so there is at least one dead cycle between words.
  - The transmitter may drop tx_ready every other cycle; this must be tolerated without byte loss or duplication.
- in_valid while busy: ignored, because in_ready=0. The upstream must hold in_data stable until accepted. No buffering beyond one word.
- Simultaneous events: the last-byte handshake and a pending in_valid in the same cycle do not accept the new word. It is accepted no earlier than the following cycle.
- Reset mid-word: the in-progress word is discarded and tx_valid drops asynchronously. There is no partial-line completion after reset.
- Counter width: ceil(log2(DIGITS)), minimum 1 bit. There is no wrap: count stops at 0 by state transition.

Test Plan:
- DIGITS=8, NEWLINE=1, tx_ready=1: in_data=0x1234abcd -> tx bytes 0x31 0x32 0x33 0x34 0x61 0x62 0x63 0x64 0x0D 0x0A on 10 consecutive cycles; first byte one cycle after accept; in_ready high on cycle 11.
- Backpressure, tx_ready toggling 1,0,1,0 and held low 5 cycles mid-word: in_data=0xdeadbeef -> exactly "deadbeef\r\n" with no repeated or dropped byte; tx_data stable during every stall.
- NEWLINE=0, DIGITS=2: words 0x0f then 0xa0 with in_valid held high -> bytes 0x30 0x66 0x61 0x30; one idle cycle between the words; second word accepted only after in_ready returns.
- in_valid pulsed with in_data=0x11111111 while a word is printing -> ignored; output is the first word only, and no byte 0x31 appears beyond the expected ones.
- Reset asserted asynchronously after the third byte of 0x89abcdef -> tx_valid=0 before the next edge, in_ready=1 after release; the next word 0x00000000 prints "00000000\r\n" cleanly.
- Boundary nibbles: 0x9a09fa0f -> 0x39 0x61 0x30 0x39 0x66 0x61 0x30 0x66, confirming the 9/a and f edges of the encoding.

Source files
------------

// File: rtl/uart_hex_tx.sv
// uart_hex_tx: prints fixed-width words as lowercase ASCII hex on a UART byte
// stream, MSB nibble first, optionally terminated by CR LF. Accepts one word per
// in_valid/in_ready handshake and drives a registered tx_valid/tx_data pair.
module uart_hex_tx #(
    parameter int unsigned DIGITS  = 8,
    parameter bit          NEWLINE = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  in_ready,
    input  logic                  in_valid,
    input  logic [4*DIGITS-1:0]   in_data,
    input  logic                  tx_ready,
    output logic                  tx_valid,
    output logic [7:0]            tx_data
);

    localparam int unsigned WordW  = 4 * DIGITS;
    // A single digit still needs a one-bit counter.
    localparam int unsigned CountW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CountW-1:0] CountLast = CountW'(DIGITS - 1);

    localparam logic [7:0] AsciiCr = 8'h0d;
    localparam logic [7:0] AsciiLf = 8'h0a;

    typedef enum logic [1:0] {
        StIdle,
        StDigit,
        StCr,
        StLf
    } state_t;

    state_t              state_q, state_d;
    logic [WordW-1:0]    word_q, word_d;
    logic [CountW-1:0]   count_q, count_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                tx_valid_q, tx_valid_d;

    // Nibble to lowercase ASCII hex.
    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return {4'h3, nib};
        end else begin
            return 8'h57 + {4'h0, nib};
        end
    endfunction

    // Byte handshake on the UART side.
    logic tx_fire;
    assign tx_fire = tx_valid_q & tx_ready;

    // Word handshake on the input side.
    logic in_fire;
    assign in_fire = in_valid & in_ready;

    // Next-state logic: the word register is shifted left so the digit being
    // sent is always taken from the top nibble.
    always_comb begin
        logic [WordW-1:0] word_shift;
        word_shift = word_q << 4;
        state_d    = state_q;
        word_d     = word_q;
        count_d    = count_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;

        unique case (state_q)
            StIdle: begin
                if (in_fire) begin
                    word_d     = in_data;
                    count_d    = CountLast;
                    tx_data_d  = hex_char(in_data[WordW-1 -: 4]);
                    tx_valid_d = 1'b1;
                    state_d    = StDigit;
                end
            end
            StDigit: begin
                if (tx_fire) begin
                    if (count_q != '0) begin
                        count_d   = count_q - 1'b1;
                        word_d    = word_shift;
                        tx_data_d = hex_char(word_shift[WordW-1 -: 4]);
                    end else if (NEWLINE) begin
                        tx_data_d = AsciiCr;
                        state_d   = StCr;
                    end else begin
                        tx_valid_d = 1'b0;
                        state_d    = StIdle;
                    end
                end
            end
            StCr: begin
                if (tx_fire) begin
                    tx_data_d = AsciiLf;
                    state_d   = StLf;
                end
            end
            StLf: begin
                if (tx_fire) begin
                    tx_valid_d = 1'b0;
                    state_d    = StIdle;
                end
            end
            default: begin
                tx_valid_d = 1'b0;
                state_d    = StIdle;
            end
        endcase
    end

    // State and datapath registers; reset discards any word in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            word_q     <= '0;
            count_q    <= '0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            count_q    <= count_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
        end
    end

    assign in_ready = (state_q == StIdle);
    assign tx_valid = tx_valid_q;
    assign tx_data  = tx_data_q;

endmodule

// File: tb/tb_uart_hex_tx.sv
// Bench for uart_hex_tx: an 8-digit CR/LF instance and a 2-digit bare instance.
// Expected byte streams come from $sformatf hex formatting of each word.
module tb_uart_hex_tx;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        in_valid8, in_ready8, tx_ready8, tx_valid8;
    logic [31:0] in_data8;
    logic [7:0]  tx_data8;

    logic        in_valid2, in_ready2, tx_ready2, tx_valid2;
    logic [7:0]  in_data2;
    logic [7:0]  tx_data2;

    uart_hex_tx #(.DIGITS(8), .NEWLINE(1'b1)) dut8 (
        .clk      (clk),
        .reset    (reset),
        .in_ready (in_ready8),
        .in_valid (in_valid8),
        .in_data  (in_data8),
        .tx_ready (tx_ready8),
        .tx_valid (tx_valid8),
        .tx_data  (tx_data8)
    );

    uart_hex_tx #(.DIGITS(2), .NEWLINE(1'b0)) dut2 (
        .clk      (clk),
        .reset    (reset),
        .in_ready (in_ready2),
        .in_valid (in_valid2),
        .in_data  (in_data2),
        .tx_ready (tx_ready2),
        .tx_valid (tx_valid2),
        .tx_data  (tx_data2)
    );

    int passed = 0;
    int total  = 0;
    int failed = 0;

    // Monitor: every byte handshake, every word accept, and any change of
    // tx_data or drop of tx_valid while stalled.
    logic [7:0] got8[$];
    int         accepts8   = 0;
    int         stall_err8 = 0;
    logic       prev_stall8 = 1'b0;
    logic [7:0] prev_data8  = 8'h00;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_stall8 <= 1'b0;
        end else begin
            if (tx_valid8 === 1'b1 && tx_ready8 === 1'b1) got8.push_back(tx_data8);
            if (in_valid8 === 1'b1 && in_ready8 === 1'b1) accepts8 <= accepts8 + 1;
            if (prev_stall8 && (tx_valid8 !== 1'b1 || tx_data8 !== prev_data8))
                stall_err8 <= stall_err8 + 1;
            prev_stall8 <= tx_valid8 && !tx_ready8;
            prev_data8  <= tx_data8;
        end
    end

    logic [7:0] exp8[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: hex text of the word followed by CR LF.
    task automatic build_exp8(input logic [31:0] w);
        string s;
        s = $sformatf("%08x", w);
        exp8.delete();
        for (int i = 0; i < s.len(); i++) exp8.push_back(s[i]);
        exp8.push_back(8'h0d);
        exp8.push_back(8'h0a);
    endtask

    // Send one word to dut8. mode 0: tx_ready high; 1: alternate with a long
    // low stretch; 2: random. pulse_at >= 0 pulses a stray word while busy.
    task automatic send_word(input logic [31:0] w, input int mode, input int pulse_at,
                             input string tag);
        int base;
        int acc0;
        int cyc;
        int n;
        build_exp8(w);
        base = got8.size();
        acc0 = accepts8;
        in_data8  = w;
        in_valid8 = 1'b1;
        tx_ready8 = 1'b1;
        cyc = 0;
        while (accepts8 == acc0 && cyc < 50) begin
            step();
            cyc++;
        end
        check({tag, " accept"}, 64'(accepts8 - acc0), 64'd1);
        in_valid8 = 1'b0;
        in_data8  = $urandom;
        cyc = 0;
        while (tx_valid8 === 1'b1 && cyc < 300) begin
            case (mode)
                0:       tx_ready8 = 1'b1;
                1:       tx_ready8 = (cyc % 2 == 0) && !(cyc >= 6 && cyc < 11);
                default: tx_ready8 = 1'($urandom_range(0, 1));
            endcase
            if (cyc == pulse_at) begin
                in_valid8 = 1'b1;
                in_data8  = 32'h11111111;
            end else begin
                in_valid8 = 1'b0;
            end
            step();
            cyc++;
        end
        in_valid8 = 1'b0;
        tx_ready8 = 1'b1;
        check({tag, " done_valid"}, 64'(tx_valid8), 64'd0);
        check({tag, " done_ready"}, 64'(in_ready8), 64'd1);
        check({tag, " one_accept"}, 64'(accepts8 - acc0), 64'd1);
        check({tag, " stall_hold"}, 64'(stall_err8), 64'd0);
        n = got8.size() - base;
        check({tag, " byte_count"}, 64'(n), 64'(exp8.size()));
        for (int i = 0; i < exp8.size(); i++) begin
            check($sformatf("%s byte%0d", tag, i),
                  64'((base + i < got8.size()) ? got8[base + i] : 8'hxx), 64'(exp8[i]));
        end
    endtask

    initial begin
        int base;
        logic [31:0] w;
        reset     = 1'b1;
        in_valid8 = 1'b0;
        in_data8  = 32'h0;
        tx_ready8 = 1'b1;
        in_valid2 = 1'b0;
        in_data2  = 8'h0;
        tx_ready2 = 1'b1;

        // Reset values.
        #1;
        check("rst tx_valid8", 64'(tx_valid8), 64'd0);
        check("rst tx_data8", 64'(tx_data8), 64'h00);
        check("rst tx_valid2", 64'(tx_valid2), 64'd0);
        step();
        step();
        reset = 1'b0;
        step();
        check("post_rst in_ready8", 64'(in_ready8), 64'd1);
        check("post_rst in_ready2", 64'(in_ready2), 64'd1);
        check("post_rst tx_valid8", 64'(tx_valid8), 64'd0);

        // Full-rate word: one byte per cycle, first byte one cycle after accept.
        build_exp8(32'h1234abcd);
        in_data8  = 32'h1234abcd;
        in_valid8 = 1'b1;
        step();
        in_valid8 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("rate valid%0d", i), 64'(tx_valid8), 64'd1);
            check($sformatf("rate data%0d", i), 64'(tx_data8), 64'(exp8[i]));
            check($sformatf("rate busy%0d", i), 64'(in_ready8), 64'd0);
            step();
        end
        check("rate end valid", 64'(tx_valid8), 64'd0);
        check("rate end ready", 64'(in_ready8), 64'd1);

        // Backpressure, stray word while busy, boundary nibbles.
        send_word(32'hdeadbeef, 1, -1, "bp");
        send_word(32'h2345abcd, 0, 3, "stray");
        send_word(32'h9a09fa0f, 0, -1, "edges");

        // Asynchronous reset after the third byte.
        base = got8.size();
        in_data8  = 32'h89abcdef;
        in_valid8 = 1'b1;
        tx_ready8 = 1'b1;
        step();
        in_valid8 = 1'b0;
        step();
        step();
        step();
        #2;
        reset = 1'b1;
        #1;
        check("arst tx_valid", 64'(tx_valid8), 64'd0);
        check("arst tx_data", 64'(tx_data8), 64'h00);
        check("arst bytes", 64'(got8.size() - base), 64'd3);
        check("arst byte2", 64'((got8.size() > base + 2) ? got8[base + 2] : 8'hxx), 64'h61);
        step();
        reset = 1'b0;
        step();
        check("arst in_ready", 64'(in_ready8), 64'd1);
        check("arst idle", 64'(tx_valid8), 64'd0);
        send_word(32'h00000000, 0, -1, "after_rst");

        // Two-digit, no newline, in_valid held high across both words.
        in_data2  = 8'h0f;
        in_valid2 = 1'b1;
        tx_ready2 = 1'b1;
        step();
        check("d2 w0 b0", 64'(tx_data2), 64'h30);
        check("d2 w0 v0", 64'(tx_valid2), 64'd1);
        check("d2 w0 busy", 64'(in_ready2), 64'd0);
        in_data2 = 8'ha0;
        step();
        check("d2 w0 b1", 64'(tx_data2), 64'h66);
        check("d2 w0 v1", 64'(tx_valid2), 64'd1);
        step();
        check("d2 gap valid", 64'(tx_valid2), 64'd0);
        check("d2 gap ready", 64'(in_ready2), 64'd1);
        step();
        check("d2 w1 b0", 64'(tx_data2), 64'h61);
        check("d2 w1 v0", 64'(tx_valid2), 64'd1);
        in_valid2 = 1'b0;
        step();
        check("d2 w1 b1", 64'(tx_data2), 64'h30);
        step();
        check("d2 end valid", 64'(tx_valid2), 64'd0);
        check("d2 end ready", 64'(in_ready2), 64'd1);

        // Random words under random backpressure.
        for (int k = 0; k < 16; k++) begin
            w = $urandom;
            send_word(w, int'($urandom_range(0, 2)), -1, $sformatf("rand%0d", k));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
